// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, ALU operation enum and control decode for the MIPS subset core.
package mips_pkg;

  localparam int unsigned MemDepth = 128;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;     // write rd instead of rt
    logic    alu_src;     // second ALU operand is the sign-extended immediate
    logic    mem_to_reg;  // write-back from data memory
    logic    reg_write;
    logic    mem_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  // Unsupported opcodes and functs decode to all-inactive controls, i.e. a NOP.
  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '{reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
          mem_write: 1'b0, branch: 1'b0, jump: 1'b0, alu_op: AluAdd};
    case (instr[31:26])
      OpRtype: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        case (instr[5:0])
          FnAdd:   c.alu_op = AluAdd;
          FnSub:   c.alu_op = AluSub;
          FnAnd:   c.alu_op = AluAnd;
          FnOr:    c.alu_op = AluOr;
          FnSlt:   c.alu_op = AluSlt;
          default: c.reg_write = 1'b0;
        endcase
      end
      OpAddi: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OpLw: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      OpSw: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OpBeq:   c.branch = 1'b1;
      OpJ:     c.jump = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two read ports, one write port, a debug read port, async clear.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
);

  logic [31:0] rf_q [32];

  // Register state; r0 is never written so it stays zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i == 5'd0) ? '0 : rf_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i == 5'd0) ? '0 : rf_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : rf_q[dbg_addr_i];

endmodule

// File: rtl/mips_main.sv
// Single-cycle MIPS-subset core with preloadable 128-word instruction and data memories.
module mips_main
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [6:0]  instructionAddress,
  input  logic [31:0] data,
  input  logic [6:0]  dataAddress,
  input  logic        writeEnable,
  input  logic [4:0]  dbgRegAddr,
  output logic [31:0] dbgRegData,
  output logic [31:0] pc
);

  logic [31:0] imem [MemDepth];
  logic [31:0] dmem [MemDepth];

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr, imm_sext, rs_val, rt_val, alu_b, alu_y, mem_rdata, wb_data;
  logic [4:0]  waddr;
  logic [6:0]  dmem_idx;
  ctrl_t       ctrl;

  assign instr    = imem[pc_q[8:2]];
  assign ctrl     = decode(instr);
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign alu_b    = ctrl.alu_src ? imm_sext : rt_val;
  assign dmem_idx = alu_y[8:2];
  assign mem_rdata = dmem[dmem_idx];
  assign wb_data  = ctrl.mem_to_reg ? mem_rdata : alu_y;
  assign waddr    = ctrl.reg_dst ? instr[15:11] : instr[20:16];
  assign pc_plus4 = pc_q + 32'd4;
  assign pc       = pc_q;

  // ALU: wrapping two's-complement arithmetic, signed set-less-than.
  always_comb begin
    alu_y = rs_val + alu_b;
    unique case (ctrl.alu_op)
      AluAdd:  alu_y = rs_val + alu_b;
      AluSub:  alu_y = rs_val - alu_b;
      AluAnd:  alu_y = rs_val & alu_b;
      AluOr:   alu_y = rs_val | alu_b;
      AluSlt:  alu_y = {31'd0, ($signed(rs_val) < $signed(alu_b))};
      default: alu_y = rs_val + alu_b;
    endcase
  end

  // Next PC: jump, taken branch, or sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jump) begin
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (ctrl.branch && (rs_val == rt_val)) begin
      pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
    end
  end

  // Program counter with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Instruction memory: written only through the load port, never reset.
  always_ff @(posedge clk) begin
    if (writeEnable) begin
      imem[instructionAddress] <= instruction;
    end
  end

  // Data memory: core store first, load port last so it wins a same-word collision.
  // The store is suppressed while reset is held so an aborted sw leaves memory intact.
  always_ff @(posedge clk) begin
    if (ctrl.mem_write && rst_n) begin
      dmem[dmem_idx] <= rt_val;
    end
    if (writeEnable) begin
      dmem[dataAddress] <= data;
    end
  end

  mips_regfile u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .raddr_a_i  (instr[25:21]),
    .rdata_a_o  (rs_val),
    .raddr_b_i  (instr[20:16]),
    .rdata_b_o  (rt_val),
    .we_i       (ctrl.reg_write),
    .waddr_i    (waddr),
    .wdata_i    (wb_data),
    .dbg_addr_i (dbgRegAddr),
    .dbg_data_o (dbgRegData)
  );

endmodule

// File: tb/tb_mips_main.sv
// Self-checking bench for mips_main: directed scenarios plus randomized programs vs an ISA model.
module tb_mips_main;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instruction = '0;
  logic [6:0]  instructionAddress = '0;
  logic [31:0] data = '0;
  logic [6:0]  dataAddress = '0;
  logic        writeEnable = 1'b0;
  logic [4:0]  dbgRegAddr = '0;
  logic [31:0] dbgRegData;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  mips_main dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .instruction        (instruction),
    .instructionAddress (instructionAddress),
    .data               (data),
    .dataAddress        (dataAddress),
    .writeEnable        (writeEnable),
    .dbgRegAddr         (dbgRegAddr),
    .dbgRegData         (dbgRegData),
    .pc                 (pc)
  );

  always #5 clk = ~clk;

  // Program/data images to load, and the ISA-level reference state.
  logic [31:0] prog [128];
  logic [31:0] dm [128];
  logic [31:0] m_imem [128];
  logic [31:0] m_dmem [128];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int target);
    return {6'h02, 26'(target)};
  endfunction

  task automatic clear_images();
    for (int i = 0; i < 128; i++) begin
      prog[i] = '0;
      dm[i]   = '0;
    end
  endtask

  task automatic model_reset();
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
  endtask

  // Executes one instruction at the ISA level.
  task automatic model_step();
    logic [31:0] ins, a, b, simm, nxt, addr, res;
    logic [5:0]  op, fn;
    int          dst;
    ins  = m_imem[m_pc[8:2]];
    op   = ins[31:26];
    fn   = ins[5:0];
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    nxt  = m_pc + 32'd4;
    dst  = 0;
    res  = '0;
    case (op)
      6'h00: begin
        dst = int'(ins[15:11]);
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: dst = 0;
        endcase
      end
      6'h08: begin dst = int'(ins[20:16]); res = a + simm; end
      6'h23: begin addr = a + simm; dst = int'(ins[20:16]); res = m_dmem[addr[8:2]]; end
      6'h2B: begin addr = a + simm; m_dmem[addr[8:2]] = b; end
      6'h04: if (a == b) nxt = nxt + (simm << 2);
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (dst != 0) m_reg[dst] = res;
    m_pc = nxt;
  endtask

  // Holds reset, loads both memories from prog/dm, then releases reset on a falling edge.
  task automatic setup();
    rst_n = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      writeEnable        = 1'b1;
      instruction        = prog[i];
      instructionAddress = 7'(i);
      data               = dm[i];
      dataAddress        = 7'(i);
      m_imem[i]          = prog[i];
      m_dmem[i]          = dm[i];
    end
    @(negedge clk);
    writeEnable = 1'b0;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_pc: got %h expected %h", pc, 32'd0);
    end
    for (int r = 0; r < 32; r += 5) begin
      dbgRegAddr = 5'(r);
      #1;
      checks++;
      if (dbgRegData !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected %h", r, dbgRegData, 32'd0);
      end
    end
  endtask

  task automatic test_first();
    clear_images();
    prog[0] = 32'h20220002;
    dm[1]   = 32'd2;
    setup();
    run(1);
    dbgRegAddr = 5'd2;
    #1;
    checks++;
    if (dbgRegData !== 32'd2) begin
      errors++;
      $display("FAIL first_r2: got %h expected %h", dbgRegData, 32'd2);
    end
    checks++;
    if (pc !== 32'd4) begin
      errors++;
      $display("FAIL first_pc: got %h expected %h", pc, 32'd4);
    end
  endtask

  task automatic load_arith();
    clear_images();
    prog[0] = enc_i(6'h08, 0, 1, 5);
    prog[1] = enc_i(6'h08, 0, 2, -3);
    prog[2] = enc_r(1, 2, 3, 6'h20);
    prog[3] = enc_r(2, 1, 4, 6'h22);
    prog[4] = enc_r(2, 1, 5, 6'h2A);
  endtask

  task automatic test_arith();
    logic [31:0] exp [3];
    load_arith();
    setup();
    run(5);
    exp[0] = 32'd2;
    exp[1] = 32'hFFFFFFF8;
    exp[2] = 32'd1;
    for (int k = 0; k < 3; k++) begin
      dbgRegAddr = 5'(3 + k);
      #1;
      checks++;
      if (dbgRegData !== exp[k]) begin
        errors++;
        $display("FAIL arith_r%0d: got %h expected %h", 3 + k, dbgRegData, exp[k]);
      end
    end
  endtask

  task automatic test_mem();
    logic [31:0] exp [3];
    clear_images();
    dm[1]   = 32'hDEADBEEF;
    prog[0] = enc_i(6'h23, 0, 6, 4);
    prog[1] = enc_i(6'h2B, 0, 6, 8);
    prog[2] = enc_i(6'h23, 0, 7, 8);
    prog[3] = enc_i(6'h2B, 0, 6, 12);
    prog[4] = enc_i(6'h23, 0, 8, 12);
    setup();
    run(3);
    // sw to dmem[3] collides with a load-port write to the same word.
    writeEnable        = 1'b1;
    instruction        = 32'd0;
    instructionAddress = 7'd100;
    data               = 32'h12345678;
    dataAddress        = 7'd3;
    @(posedge clk);
    @(negedge clk);
    writeEnable = 1'b0;
    run(1);
    exp[0] = 32'hDEADBEEF;
    exp[1] = 32'hDEADBEEF;
    exp[2] = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      dbgRegAddr = 5'(6 + k);
      #1;
      checks++;
      if (dbgRegData !== exp[k]) begin
        errors++;
        $display("FAIL mem_r%0d: got %h expected %h", 6 + k, dbgRegData, exp[k]);
      end
    end
  endtask

  task automatic test_branch_jump();
    clear_images();
    prog[0] = enc_i(6'h04, 0, 0, 2);
    setup();
    run(1);
    checks++;
    if (pc !== 32'd12) begin
      errors++;
      $display("FAIL beq_taken_pc: got %h expected %h", pc, 32'd12);
    end
    clear_images();
    prog[0] = enc_i(6'h08, 0, 1, 1);
    prog[1] = enc_i(6'h04, 0, 1, 5);
    setup();
    run(2);
    checks++;
    if (pc !== 32'd8) begin
      errors++;
      $display("FAIL beq_not_taken_pc: got %h expected %h", pc, 32'd8);
    end
    clear_images();
    prog[0] = enc_j(32'h10);
    setup();
    run(1);
    checks++;
    if (pc !== 32'h40) begin
      errors++;
      $display("FAIL j_pc: got %h expected %h", pc, 32'h40);
    end
  endtask

  task automatic test_r0_unknown();
    clear_images();
    prog[0] = enc_i(6'h08, 0, 0, 7);
    prog[1] = 32'hFC221234;
    prog[2] = enc_r(1, 2, 3, 6'h21);
    setup();
    run(3);
    checks++;
    if (pc !== 32'd12) begin
      errors++;
      $display("FAIL nop_pc: got %h expected %h", pc, 32'd12);
    end
    for (int r = 0; r < 4; r++) begin
      dbgRegAddr = 5'(r);
      #1;
      checks++;
      if (dbgRegData !== 32'd0) begin
        errors++;
        $display("FAIL nop_reg%0d: got %h expected %h", r, dbgRegData, 32'd0);
      end
    end
  endtask

  task automatic test_imem_load_live();
    clear_images();
    prog[0] = enc_j(0);
    setup();
    run(2);
    // Overwrite the word currently being fetched; the old j executes on this edge.
    writeEnable        = 1'b1;
    instruction        = enc_i(6'h08, 0, 1, 9);
    instructionAddress = 7'd0;
    data               = 32'd0;
    dataAddress        = 7'd50;
    @(posedge clk);
    @(negedge clk);
    writeEnable = 1'b0;
    dbgRegAddr  = 5'd1;
    #1;
    checks++;
    if (pc !== 32'd0 || dbgRegData !== 32'd0) begin
      errors++;
      $display("FAIL live_load_old: got pc %h r1 %h expected pc 0 r1 0", pc, dbgRegData);
    end
    @(negedge clk);
    #1;
    checks++;
    if (pc !== 32'd4 || dbgRegData !== 32'd9) begin
      errors++;
      $display("FAIL live_load_new: got pc %h r1 %h expected pc 4 r1 9", pc, dbgRegData);
    end
  endtask

  task automatic test_reset_mid();
    load_arith();
    setup();
    run(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'd0) begin
      errors++;
      $display("FAIL midreset_pc: got %h expected %h", pc, 32'd0);
    end
    for (int r = 1; r < 6; r++) begin
      dbgRegAddr = 5'(r);
      #1;
      checks++;
      if (dbgRegData !== 32'd0) begin
        errors++;
        $display("FAIL midreset_reg%0d: got %h expected %h", r, dbgRegData, 32'd0);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(5);
    checks++;
    if (pc !== 32'd20) begin
      errors++;
      $display("FAIL rerun_pc: got %h expected %h", pc, 32'd20);
    end
    dbgRegAddr = 5'd4;
    #1;
    checks++;
    if (dbgRegData !== 32'hFFFFFFF8) begin
      errors++;
      $display("FAIL rerun_r4: got %h expected %h", dbgRegData, 32'hFFFFFFF8);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd, sel;
    logic [5:0] fns [5];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    rs  = int'($urandom_range(0, 7));
    rt  = int'($urandom_range(0, 7));
    rd  = int'($urandom_range(0, 7));
    sel = int'($urandom_range(0, 11));
    case (sel)
      0, 1, 2, 3, 4: return enc_r(rs, rt, rd, fns[sel]);
      5:  return enc_i(6'h08, rs, rt, int'($urandom_range(0, 65535)));
      6:  return enc_i(6'h23, rs, rt, int'($urandom_range(0, 31)) * 4);
      7:  return enc_i(6'h2B, rs, rt, int'($urandom_range(0, 31)) * 4);
      8:  return enc_i(6'h04, rs, rt, int'($urandom_range(0, 8)) - 4);
      9:  return enc_j(int'($urandom_range(0, 127)));
      10: return 32'd0;
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  task automatic test_random();
    int r;
    bit load;
    for (int iter = 0; iter < 4; iter++) begin
      for (int i = 0; i < 128; i++) begin
        prog[i] = rand_instr();
        dm[i]   = $urandom;
      end
      setup();
      for (int c = 0; c < 120; c++) begin
        load = ($urandom_range(0, 3) == 0);
        if (load) begin
          writeEnable        = 1'b1;
          instruction        = rand_instr();
          instructionAddress = 7'($urandom_range(0, 127));
          data               = $urandom;
          dataAddress        = 7'($urandom_range(0, 31));
        end
        @(posedge clk);
        model_step();
        if (load) begin
          m_imem[instructionAddress] = instruction;
          m_dmem[dataAddress]        = data;
        end
        @(negedge clk);
        writeEnable = 1'b0;
        checks++;
        if (pc !== m_pc) begin
          errors++;
          $display("FAIL rand_pc it%0d cyc%0d: got %h expected %h", iter, c, pc, m_pc);
        end
        for (int k = 0; k < 3; k++) begin
          r = int'($urandom_range(0, 7));
          dbgRegAddr = 5'(r);
          #1;
          checks++;
          if (dbgRegData !== m_reg[r]) begin
            errors++;
            $display("FAIL rand_reg%0d it%0d cyc%0d: got %h expected %h",
                     r, iter, c, dbgRegData, m_reg[r]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_arith();
    test_mem();
    test_branch_jump();
    test_r0_unknown();
    test_imem_load_live();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
